// File: rtl/capture_pkg.sv
// Shared definitions for the logic-analyzer capture controller.
//   cap_state_t : capture FSM states
//   ADDR_W_DEF  : default sample RAM address width
//   depth_f()   : sample RAM depth for a given address width
package capture_pkg;

   localparam int ADDR_W_DEF = 9;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } cap_state_t;

   function automatic int depth_f(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/capture_if.sv
// Capture controller bus: start/strobe/trigger inputs and RAM/status outputs.
//   capture_en, smpl_en, trig_in, trig_pos : driven by the command/decimator side
//   we, waddr                             : sample RAM write port
//   trig_addr, armed, triggered, capture_done : status to readout logic
// Modports: master = upstream driver, slave = capture_ctrl.
interface capture_if #(
   parameter int ADDR_W = capture_pkg::ADDR_W_DEF
);
   logic              capture_en;
   logic              smpl_en;
   logic              trig_in;
   logic [ADDR_W-1:0] trig_pos;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] trig_addr;
   logic              armed;
   logic              triggered;
   logic              capture_done;

   modport master (
      output capture_en, smpl_en, trig_in, trig_pos,
      input  we, waddr, trig_addr, armed, triggered, capture_done
   );

   modport slave (
      input  capture_en, smpl_en, trig_in, trig_pos,
      output we, waddr, trig_addr, armed, triggered, capture_done
   );
endinterface

// File: rtl/wrap_cntr.sv
// Up-counter with synchronous clear, count enable and modulo wrap.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : clear to 0 (priority over i_en)
//   i_en     : advance by one, wrapping MODULO-1 -> 0
//   o_cnt    : current count
module wrap_cntr #(
   parameter int W      = 9,
   parameter int MODULO = 1 << W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);
   localparam logic [W-1:0] LAST = W'(MODULO - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: circular sample-RAM writer with pre-trigger fill,
// arming, trigger address capture and a programmable post-trigger count.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : capture_if.slave (start/strobe/trigger in, RAM write port
//              and run status out)
module capture_ctrl
   import capture_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic      clk,
   input  logic      rst,
   capture_if.slave  bus
);
   localparam int              DEPTH   = depth_f(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   cap_state_t        r_state;
   logic [ADDR_W:0]   r_tpos;
   logic [ADDR_W:0]   r_pre_cnt;
   logic [ADDR_W:0]   r_post_cnt;
   logic [ADDR_W-1:0] r_trig_addr;
   logic              r_armed;
   logic              r_triggered;
   logic              r_done;

   logic              w_start;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [ADDR_W:0]   w_pre_nxt;
   logic [ADDR_W:0]   w_post_nxt;

   // A start in the same cycle as a strobe drops the strobe.
   assign w_start    = bus.capture_en;
   assign w_we       = bus.smpl_en & ~w_start &
                       ((r_state == FILL) | (r_state == ARMED) | (r_state == POST));
   assign w_pre_nxt  = r_pre_cnt + 1'b1;
   assign w_post_nxt = r_post_cnt + 1'b1;

   wrap_cntr #(
      .W      (ADDR_W),
      .MODULO (DEPTH)
   ) u_waddr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start),
      .i_en  (w_we),
      .o_cnt (w_waddr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tpos      <= ONE_C;
         r_pre_cnt   <= '0;
         r_post_cnt  <= '0;
         r_trig_addr <= '0;
         r_armed     <= 1'b0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
      end else if (w_start) begin
         r_state     <= FILL;
         r_tpos      <= (bus.trig_pos == '0) ? ONE_C : {1'b0, bus.trig_pos};
         r_pre_cnt   <= '0;
         r_post_cnt  <= '0;
         r_armed     <= 1'b0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               // Triggers are ignored here, even on the write that arms.
               if (w_we) begin
                  r_pre_cnt <= w_pre_nxt;
                  if (w_pre_nxt == DEPTH_C - r_tpos) begin
                     r_state <= ARMED;
                     r_armed <= 1'b1;
                  end
               end
            end
            ARMED: begin
               if (bus.trig_in) begin
                  r_trig_addr <= w_waddr;
                  r_triggered <= 1'b1;
                  r_armed     <= 1'b0;
                  // A coincident strobe is post sample 1.
                  if (bus.smpl_en) begin
                     if (r_tpos == ONE_C) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state    <= POST;
                        r_post_cnt <= ONE_C;
                     end
                  end else begin
                     r_state    <= POST;
                     r_post_cnt <= '0;
                  end
               end
            end
            POST: begin
               if (w_we) begin
                  r_post_cnt <= w_post_nxt;
                  if (w_post_nxt == r_tpos) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.we           = w_we;
   assign bus.waddr        = w_waddr;
   assign bus.trig_addr    = r_trig_addr;
   assign bus.armed        = r_armed;
   assign bus.triggered    = r_triggered;
   assign bus.capture_done = r_done;
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture controller for the logic-analyzer sample buffer; sits directly downstream of the SPI protocol trigger and consumes its one-cycle `SPItrig` pulse. It runs a circular write pointer into the sample RAM, fills a programmable pre-trigger window, arms, accepts the trigger, and records the trigger address. It then writes a programmable number of post-trigger samples and flags completion to the command/readout logic.

## Interface
- `ADDR_W`, default 9: sample RAM address width; DEPTH = 2**ADDR_W.
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `capture_en` input 1: one-cycle start pulse. Starts a run from any state, aborting any run in progress.
- `smpl_en` input 1: sample strobe from the decimator. At most one sample per strobe.
- `trig_in` input 1: one-cycle trigger pulse (`SPItrig`).
- `trig_pos` input ADDR_W: number of post-trigger samples; sampled at `capture_en`. A value of 0 is treated as 1.
- `we` output 1: RAM write enable, combinational.
- `waddr` output ADDR_W: RAM write address (current pointer register).
- `trig_addr` output ADDR_W: address of the first post-trigger sample.
- `armed` output 1: pre-trigger window is full and triggers are accepted.
- `triggered` output 1: trigger has been accepted in this run.
- `capture_done` output 1: run complete; level signal.

## Operation
- States (`cap_state_t`): IDLE, FILL, ARMED, POST, DONE.
- `capture_en` (any state):
  - next state FILL
  - `waddr`←0, `pre_cnt`←0, `post_cnt`←0
  - latch `tpos` = max(`trig_pos`,1)
  - clear `armed`, `triggered`, `capture_done`
- Write rule:
  - `we` = `smpl_en` & state∈{FILL, ARMED, POST}.
  - Each write advances `waddr` by 1, modulo DEPTH (wraps DEPTH-1→0).
- FILL:
  - Each write increments `pre_cnt` (ADDR_W+1 bits).
  - When the write makes `pre_cnt` == DEPTH−`tpos`, go to ARMED next cycle and set `armed`.
  - `trig_in` is ignored in FILL, including on that final write cycle.
- ARMED, `trig_in` & `smpl_en` in the same cycle:
  - `trig_addr`←`waddr`; this write is post sample 1.
  - If `tpos`==1 go to DONE, else go to POST with `post_cnt`=1.
- ARMED, `trig_in` without `smpl_en`: `trig_addr`←`waddr`; go to POST with `post_cnt`=0.
- On trigger acceptance, `triggered`←1 and `armed`←0.
- ARMED, no trigger: writes continue and wrap, so the oldest samples are overwritten.
- POST:
  - Each write increments `post_cnt`.
  - The write that makes `post_cnt` == `tpos` moves the state to DONE.
  - `trig_in` is ignored.
- DONE:
  - `capture_done`=1, `we`=0, `waddr` frozen; it then points at the oldest sample in the buffer.
  - Remains in DONE until `capture_en` or `rst`.
- IDLE: `we`=0; all inputs ignored except `capture_en`.
- Invariant: DONE implies exactly DEPTH−`tpos` pre samples and `tpos` post samples written, counting from `trig_addr`.

## Timing
- Reset values: state IDLE; `waddr`, `trig_addr`, counters = 0; `armed`, `triggered`, `capture_done` = 0; `we` = 0.
- `rst` mid-run aborts immediately to the reset values; there is no partial-run state.
- `we` is valid in the same cycle as `smpl_en`, with zero latency.
- `waddr` updates on the clock edge ending the write cycle.
- `armed`, `triggered`, and `capture_done` are registered and assert in the cycle after the qualifying write or trigger.
- `capture_en` together with `trig_in` or `smpl_en` in the same cycle: start wins, and the strobe or trigger is dropped.
- `trig_pos` changes mid-run have no effect, because `tpos` is latched at start.

## Structure
- Package `capture_pkg`: `cap_state_t` enum, default `ADDR_W`, and the DEPTH localparam function.
- Sub-module `wrap_cntr`: parameterized up-counter with clear, enable, and modulo wrap. Used for `waddr`.
- `pre_cnt` and `post_cnt` are inline counters in `capture_ctrl`.

## Test plan
- All scenarios use `ADDR_W`=4 (DEPTH 16).
1. `trig_pos`=4, `capture_en`, 12 strobes → `we` on each strobe at addresses 0..11; `armed`=1 the cycle after the 12th strobe; `waddr`=12.
2. Same setup with `trig_in` pulsed at the 5th strobe and again on the 12th strobe cycle → both ignored, `triggered`=0; `armed` still rises after the 12th write.
3. Armed with 2 extra writes (`waddr`=14), then `trig_in`+`smpl_en` → `trig_addr`=14; writes at 14, 15, 0, 1; `capture_done`=1 after the 4th; `waddr`=2; further strobes give `we`=0.
4. Armed, `trig_in` alone at `waddr`=5 → `trig_addr`=5; next 4 strobes write 5..8 then DONE. Separately, `trig_pos`=0 with `trig_in`+`smpl_en` → single post write, then DONE.
5. In DONE, `capture_en` → `capture_done`/`triggered`/`armed` clear next cycle, `waddr`=0, state FILL. Also `capture_en` mid-POST → restart identical to a fresh start.
6. `rst` asserted during POST → outputs return to reset values asynchronously; after deassert, `smpl_en` gives `we`=0 until `capture_en`.
